// File: rtl/dram_rw_queue.sv
// DEPTH-entry request queue between the core memory port and the external DRAM
// controller: buffers full requests, issues one at a time, and flags overflow / ack timeout.
module dram_rw_queue #(
    parameter int ADDR_BITS   = 22,
    parameter int DATA_BITS   = 32,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_BITS-1:0]       req_addr,
    input  logic                       req_read_en,
    input  logic                       req_write_en,
    input  logic [DATA_BITS/8-1:0]     req_byte_enable,
    input  logic [DATA_BITS-1:0]       req_write_data,
    output logic                       req_ready,
    input  logic                       ext_dram_ack,
    input  logic [DATA_BITS-1:0]       ext_dram_mem_read_data,
    output logic [ADDR_BITS-1:0]       ext_dram_mem_addr,
    output logic                       ext_dram_mem_read_en,
    output logic                       ext_dram_mem_write_en,
    output logic [DATA_BITS/8-1:0]     ext_dram_mem_byte_enable,
    output logic [DATA_BITS-1:0]       ext_dram_mem_write_data,
    output logic                       dram_ack,
    output logic [DATA_BITS-1:0]       dram_mem_read_data,
    output logic                       dram_rw_pending,
    output logic [$clog2(DEPTH):0]     buf_cnt,
    output logic                       err_overflow,
    output logic                       err_timeout,
    input  logic                       err_clear
);

    localparam int BE_BITS  = DATA_BITS / 8;
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int WD_BITS  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic                 is_write;
        logic [ADDR_BITS-1:0] addr;
        logic [BE_BITS-1:0]   be;
        logic [DATA_BITS-1:0] wdata;
    } entry_t;

    entry_t               mem_q [DEPTH];
    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WD_BITS-1:0]   wdog_q, wdog_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BE_BITS-1:0]   be_q, be_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                 err_ovf_q, err_ovf_d, err_to_q, err_to_d;

    logic   req_any, push, pop;
    entry_t head, push_entry;

    assign req_any    = req_read_en | req_write_en;
    assign req_ready  = count_q < CNT_BITS'(DEPTH);
    assign push       = req_any & req_ready;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    // A simultaneous read and write strobe is treated as a write.
    assign push_entry = '{is_write: req_write_en, addr: req_addr,
                          be: req_byte_enable, wdata: req_write_data};

    always_comb begin
        // NOTE: every _d starts from its _q (or a safe value) so no path leaves it unassigned and infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wdog_d   = wdog_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        err_ovf_d = (err_ovf_q & ~err_clear) | (req_any & ~req_ready);
        err_to_d  = err_to_q & ~err_clear;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d   = head.addr;
                    be_d     = head.be;
                    wdata_d  = head.wdata;
                    rd_en_d  = ~head.is_write;
                    wr_en_d  = head.is_write;
                    wdog_d   = '0;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = ext_dram_ack ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (ext_dram_ack) begin
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    // Watchdog expiry abandons the request; a later ack lands in IDLE and is ignored.
                    if (ACK_TIMEOUT != 0 && wdog_d == WD_BITS'(ACK_TIMEOUT)) begin
                        err_to_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wdog_q    <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wdog_q    <= wdog_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            err_ovf_q <= err_ovf_d;
            err_to_q  <= err_to_d;
        end
    end

    // NOTE: queue storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign ext_dram_mem_addr        = addr_q;
    assign ext_dram_mem_read_en     = rd_en_q;
    assign ext_dram_mem_write_en    = wr_en_q;
    assign ext_dram_mem_byte_enable = be_q;
    assign ext_dram_mem_write_data  = wdata_q;
    assign dram_ack           = ext_dram_ack & ((state_q == S_ISSUE) | (state_q == S_WAIT));
    assign dram_mem_read_data = ext_dram_mem_read_data;
    assign dram_rw_pending    = (count_q != '0) | (state_q != S_IDLE);
    assign buf_cnt            = count_q;
    assign err_overflow       = err_ovf_q;
    assign err_timeout        = err_to_q;

endmodule
